flit_stream_order_checker: RTL and testbench
============================================

Name: flit_stream_order_checker

Overview:
- Per-input-port protocol checker for a NoC router input flit channel.
- Tracks header/body/tail ordering per virtual channel (VC) and counts flits per packet.
- Flags ordering, packet-type, VC-encoding and minimum-packet-size violations as registered error pulses plus a sticky flag.
- Passive: sits beside the router input and never alters traffic.

Parameters:
- V, 4, number of VCs; width of the one-hot VC field.
- PCK_TYPE, "MULTI_FLIT", "MULTI_FLIT" or "SINGLE_FLIT".
- MIN_PCK_SIZE, 2, minimum legal packet length in flits (≥1).
- CNTw, 8, per-VC flit counter width; the counter saturates.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- flit_in_wr  input  1  flit valid this cycle.
- hdr_flg_in  input  1  header flag of incoming flit.
- tail_flg_in  input  1  tail flag of incoming flit.
- vc_num_in  input  V  one-hot VC of incoming flit.
- err_hdr_in_pck_o  output  1  header arrived on a VC already inside a packet.
- err_no_hdr_o  output  1  body/tail arrived on an idle VC.
- err_type_o  output  1  flit type illegal for PCK_TYPE.
- err_size_o  output  1  packet closed with fewer than MIN_PCK_SIZE flits.
- err_vc_onehot_o  output  1  vc_num_in not one-hot while flit_in_wr=1.
- err_vc_o  output  V  VC of the flagged flit (copy of vc_num_in).
- error_sticky_o  output  1  OR of all errors since reset.
- pck_done_o  output  1  a packet closed on a tail flit.
- pck_size_o  output  CNTw  flit count of the closed packet.

Behaviour:
- Reset (reset=0, asynchronous): all VC active bits = 0, counters = 0, all outputs = 0.
- Per-VC state: active bit and count[CNTw].
- All outputs are registered and appear one cycle after the sampled write. Pulse outputs are high for exactly one cycle.
- flit_in_wr=0: no state change; all pulse outputs 0 next cycle.
- flit_in_wr=1 with vc_num_in not one-hot (zero or multiple bits):
  - err_vc_onehot pulses; err_vc_o = vc_num_in.
  - No VC state updates; no other checks.
- Valid write to VC k, decided on (hdr, tail):
  - hdr=1, tail=1 (single-flit packet):
    - err_hdr_in_pck if active[k].
    - err_size if MIN_PCK_SIZE>1.
    - pck_done pulses with pck_size=1.
    - active[k]=0, count[k]=0.
  - hdr=1, tail=0:
    - err_type if PCK_TYPE=="SINGLE_FLIT".
    - err_hdr_in_pck if active[k]; the old packet is abandoned without pck_done.
    - active[k]=1, count[k]=1.
  - hdr=0, any tail:
    - err_type if PCK_TYPE=="SINGLE_FLIT".
    - If !active[k]: err_no_hdr; state unchanged; no pck_done.
    - Else n = count[k]+1, saturating at 2^CNTw−1; count[k]=n.
    - If tail=1 and active[k]: pck_done pulses with pck_size=n; err_size if n<MIN_PCK_SIZE; active[k]=0, count[k]=0.
- err_vc_o = vc_num_in whenever any error pulses, else 0.
- Multiple errors from one flit pulse simultaneously.
- Independent VCs interleave freely; only one flit per cycle.
- error_sticky sets on any error pulse and is cleared only by reset.
- Reset mid-packet discards all progress; the first flit after reset is checked against idle state.

Test Plan:
- V=4, MIN=2: H(vc0001), B, T → no errors; pck_done=1, pck_size=3 the cycle after T.
- Interleave H vc0001, H vc0010, T vc0001, T vc0010 → two pck_done pulses (size 2, size 2); no errors.
- B on idle vc0100 → err_no_hdr=1, err_vc_o=0100, error_sticky=1 and stays 1; next H/T on vc0100 is legal.
- H vc0001, then H vc0001 again, then T → err_hdr_in_pck on the second H; T gives pck_size=2, no err_size.
- Single-flit H+T with MIN=2 → err_size=1, pck_done, pck_size=1; with PCK_TYPE="SINGLE_FLIT", MIN=1, H-only flit → err_type=1.
- Write with vc_num_in=0011 → err_vc_onehot=1, no state change. Assert reset low mid-packet, then send T → err_no_hdr=1.

Source files
------------

// File: rtl/flit_stream_order_checker.sv
// ============================================================================
// Module   : flit_stream_order_checker
// Brief    : Passive per-input-port checker for a NoC router flit channel.
//            Tracks header/body/tail ordering per one-hot VC, counts flits
//            per packet and reports protocol violations as registered
//            one-cycle pulses plus a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flit_stream_order_checker #(
  parameter int    V            = 4,
  parameter string PCK_TYPE     = "MULTI_FLIT",
  parameter int    MIN_PCK_SIZE = 2,
  parameter int    CNTw         = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flit_in_wr,
  input  logic            hdr_flg_in,
  input  logic            tail_flg_in,
  input  logic [V-1:0]    vc_num_in,
  output logic            err_hdr_in_pck_o,
  output logic            err_no_hdr_o,
  output logic            err_type_o,
  output logic            err_size_o,
  output logic            err_vc_onehot_o,
  output logic [V-1:0]    err_vc_o,
  output logic            error_sticky_o,
  output logic            pck_done_o,
  output logic [CNTw-1:0] pck_size_o
);

  // Only header+tail flits are legal when the port carries single-flit packets.
  localparam logic c_is_single   = (PCK_TYPE == "SINGLE_FLIT");
  // A one-flit packet is too short whenever the minimum exceeds one flit.
  localparam logic c_single_short = (MIN_PCK_SIZE > 1);

  logic [V-1:0]    active_q, active_d;
  logic [CNTw-1:0] count_q [V];
  logic [CNTw-1:0] count_d [V];
  logic            err_hip_q, err_hip_d;
  logic            err_nh_q, err_nh_d;
  logic            err_type_q, err_type_d;
  logic            err_size_q, err_size_d;
  logic            err_oh_q, err_oh_d;
  logic [V-1:0]    err_vc_q, err_vc_d;
  logic            sticky_q, sticky_d;
  logic            done_q, done_d;
  logic [CNTw-1:0] size_q, size_d;

  logic            sel_active;
  logic [CNTw-1:0] sel_count;
  logic [CNTw-1:0] n_sat;
  logic            vc_write;
  logic            next_active;
  logic [CNTw-1:0] next_count;
  logic            any_err;

  // Decode the flit against the state of its VC and compute next state/outputs.
  always_comb begin
    active_d   = active_q;
    count_d    = count_q;
    err_hip_d  = 1'b0;
    err_nh_d   = 1'b0;
    err_type_d = 1'b0;
    err_size_d = 1'b0;
    err_oh_d   = 1'b0;
    done_d     = 1'b0;
    size_d     = '0;
    vc_write   = 1'b0;
    next_active = 1'b0;
    next_count = '0;

    // One-hot select of the addressed VC's state (only meaningful if one-hot).
    sel_active = 1'b0;
    sel_count  = '0;
    for (int i = 0; i < V; i++) begin
      if (vc_num_in[i]) begin
        sel_active = sel_active | active_q[i];
        sel_count  = sel_count | count_q[i];
      end
    end
    n_sat = (sel_count == {CNTw{1'b1}}) ? sel_count : sel_count + CNTw'(1);

    if (flit_in_wr) begin
      if (!$onehot(vc_num_in)) begin
        // Unaddressable flit: report it and leave every VC untouched.
        err_oh_d = 1'b1;
      end else begin
        case ({hdr_flg_in, tail_flg_in})
          2'b11: begin
            err_hip_d   = sel_active;
            err_size_d  = c_single_short;
            done_d      = 1'b1;
            size_d      = CNTw'(1);
            vc_write    = 1'b1;
            next_active = 1'b0;
            next_count  = '0;
          end
          2'b10: begin
            // A header inside an open packet abandons the old packet silently.
            err_type_d  = c_is_single;
            err_hip_d   = sel_active;
            vc_write    = 1'b1;
            next_active = 1'b1;
            next_count  = CNTw'(1);
          end
          default: begin
            err_type_d = c_is_single;
            if (!sel_active) begin
              err_nh_d = 1'b1;
            end else begin
              vc_write    = 1'b1;
              next_active = 1'b1;
              next_count  = n_sat;
              if (tail_flg_in) begin
                done_d      = 1'b1;
                size_d      = n_sat;
                err_size_d  = (int'(n_sat) < MIN_PCK_SIZE);
                next_active = 1'b0;
                next_count  = '0;
              end
            end
          end
        endcase
      end
    end

    for (int i = 0; i < V; i++) begin
      if (vc_write && vc_num_in[i]) begin
        active_d[i] = next_active;
        count_d[i]  = next_count;
      end
    end

    any_err  = err_hip_d | err_nh_d | err_type_d | err_size_d | err_oh_d;
    err_vc_d = any_err ? vc_num_in : '0;
    sticky_d = sticky_q | any_err;
  end

  // Register VC state and all outputs; reset discards any packet in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q   <= '0;
      for (int i = 0; i < V; i++) count_q[i] <= '0;
      err_hip_q  <= 1'b0;
      err_nh_q   <= 1'b0;
      err_type_q <= 1'b0;
      err_size_q <= 1'b0;
      err_oh_q   <= 1'b0;
      err_vc_q   <= '0;
      sticky_q   <= 1'b0;
      done_q     <= 1'b0;
      size_q     <= '0;
    end else begin
      active_q   <= active_d;
      count_q    <= count_d;
      err_hip_q  <= err_hip_d;
      err_nh_q   <= err_nh_d;
      err_type_q <= err_type_d;
      err_size_q <= err_size_d;
      err_oh_q   <= err_oh_d;
      err_vc_q   <= err_vc_d;
      sticky_q   <= sticky_d;
      done_q     <= done_d;
      size_q     <= size_d;
    end
  end

  assign err_hdr_in_pck_o = err_hip_q;
  assign err_no_hdr_o     = err_nh_q;
  assign err_type_o       = err_type_q;
  assign err_size_o       = err_size_q;
  assign err_vc_onehot_o  = err_oh_q;
  assign err_vc_o         = err_vc_q;
  assign error_sticky_o   = sticky_q;
  assign pck_done_o       = done_q;
  assign pck_size_o       = size_q;

endmodule

`default_nettype wire

// File: tb/tb_flit_stream_order_checker.sv
// ============================================================================
// Module   : tb_flit_stream_order_checker
// Brief    : Self-checking bench for flit_stream_order_checker. Two instances
//            share one stimulus stream: A = MULTI_FLIT/MIN 2/8-bit counters,
//            B = SINGLE_FLIT/MIN 1/3-bit counters (so saturation is cheap).
//            Expected outputs come from a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flit_stream_order_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flit_in_wr = 1'b0;
  logic       hdr_flg_in = 1'b0;
  logic       tail_flg_in = 1'b0;
  logic [3:0] vc_num_in = 4'b0;

  logic       a_hip, a_nh, a_ty, a_sz, a_oh, a_sticky, a_done;
  logic [3:0] a_vc;
  logic [7:0] a_size;
  logic       b_hip, b_nh, b_ty, b_sz, b_oh, b_sticky, b_done;
  logic [3:0] b_vc;
  logic [2:0] b_size;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  flit_stream_order_checker dut_a (
    .clk(clk), .reset(reset), .flit_in_wr(flit_in_wr),
    .hdr_flg_in(hdr_flg_in), .tail_flg_in(tail_flg_in), .vc_num_in(vc_num_in),
    .err_hdr_in_pck_o(a_hip), .err_no_hdr_o(a_nh), .err_type_o(a_ty),
    .err_size_o(a_sz), .err_vc_onehot_o(a_oh), .err_vc_o(a_vc),
    .error_sticky_o(a_sticky), .pck_done_o(a_done), .pck_size_o(a_size)
  );

  flit_stream_order_checker #(
    .V(4), .PCK_TYPE("SINGLE_FLIT"), .MIN_PCK_SIZE(1), .CNTw(3)
  ) dut_b (
    .clk(clk), .reset(reset), .flit_in_wr(flit_in_wr),
    .hdr_flg_in(hdr_flg_in), .tail_flg_in(tail_flg_in), .vc_num_in(vc_num_in),
    .err_hdr_in_pck_o(b_hip), .err_no_hdr_o(b_nh), .err_type_o(b_ty),
    .err_size_o(b_sz), .err_vc_onehot_o(b_oh), .err_vc_o(b_vc),
    .error_sticky_o(b_sticky), .pck_done_o(b_done), .pck_size_o(b_size)
  );

  // Observed outputs of both instances, packed for whole-cycle comparison.
  logic [32:0] obs;
  assign obs = {a_hip, a_nh, a_ty, a_sz, a_oh, a_vc, a_sticky, a_done, a_size,
                b_hip, b_nh, b_ty, b_sz, b_oh, b_vc, b_sticky, b_done, b_size};

  // ---------------- reference model (packet level, per config) -------------
  int  c_min [2]    = '{2, 1};
  int  c_max [2]    = '{255, 7};
  bit  c_single [2] = '{1'b0, 1'b1};

  bit   m_open [2][4];
  int   m_len  [2][4];
  bit   m_sticky [2];
  bit   m_hip [2], m_nh [2], m_ty [2], m_sz [2], m_oh [2], m_done [2];
  logic [3:0] m_vc [2];
  int   m_size [2];

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int v = 0; v < 4; v++) begin
        m_open[c][v] = 1'b0;
        m_len[c][v]  = 0;
      end
      m_sticky[c] = 1'b0;
      m_hip[c] = 1'b0; m_nh[c] = 1'b0; m_ty[c] = 1'b0; m_sz[c] = 1'b0;
      m_oh[c] = 1'b0; m_done[c] = 1'b0; m_vc[c] = 4'b0; m_size[c] = 0;
    end
  endfunction

  function automatic void model_step(bit wr, bit hdr, bit tail, logic [3:0] vc);
    int  k;
    int  sz;
    bit  any;
    for (int c = 0; c < 2; c++) begin
      m_hip[c] = 1'b0; m_nh[c] = 1'b0; m_ty[c] = 1'b0; m_sz[c] = 1'b0;
      m_oh[c] = 1'b0; m_done[c] = 1'b0; m_vc[c] = 4'b0; m_size[c] = 0;
      if (wr) begin
        if ($countones(vc) != 1) begin
          m_oh[c] = 1'b1;
        end else begin
          k = 0;
          for (int v = 0; v < 4; v++) if (vc[v]) k = v;
          if (hdr && tail) begin
            m_hip[c]  = m_open[c][k];
            m_sz[c]   = (c_min[c] > 1);
            m_done[c] = 1'b1;
            m_size[c] = 1;
            m_open[c][k] = 1'b0;
            m_len[c][k]  = 0;
          end else if (hdr) begin
            m_ty[c]  = c_single[c];
            m_hip[c] = m_open[c][k];
            m_open[c][k] = 1'b1;
            m_len[c][k]  = 1;
          end else begin
            m_ty[c] = c_single[c];
            if (!m_open[c][k]) begin
              m_nh[c] = 1'b1;
            end else begin
              m_len[c][k]++;
              if (tail) begin
                sz = (m_len[c][k] > c_max[c]) ? c_max[c] : m_len[c][k];
                m_done[c] = 1'b1;
                m_size[c] = sz;
                m_sz[c]   = (sz < c_min[c]);
                m_open[c][k] = 1'b0;
                m_len[c][k]  = 0;
              end
            end
          end
        end
      end
      any = m_hip[c] | m_nh[c] | m_ty[c] | m_sz[c] | m_oh[c];
      m_vc[c] = any ? vc : 4'b0;
      m_sticky[c] = m_sticky[c] | any;
    end
  endfunction

  function automatic logic [32:0] expv();
    logic [7:0] sa;
    logic [2:0] sb;
    sa = 8'(m_size[0]);
    sb = 3'(m_size[1]);
    return {m_hip[0], m_nh[0], m_ty[0], m_sz[0], m_oh[0], m_vc[0], m_sticky[0], m_done[0], sa,
            m_hip[1], m_nh[1], m_ty[1], m_sz[1], m_oh[1], m_vc[1], m_sticky[1], m_done[1], sb};
  endfunction

  // Drive one flit at the falling edge, advance the model, then wait until
  // just after the rising edge that registers the result.
  task automatic apply(input bit wr, input bit hdr, input bit tail, input logic [3:0] vc);
    @(negedge clk);
    flit_in_wr  = wr;
    hdr_flg_in  = hdr;
    tail_flg_in = tail;
    vc_num_in   = vc;
    model_step(wr, hdr, tail, vc);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    model_reset();
    #2;
    vectors++;
    if (obs !== expv()) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", obs, expv());
    end
    @(negedge clk);
    reset = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 4'b0);
    vectors++;
    if (obs !== expv()) begin
      miscompares++;
      $display("FAIL reset_idle: got %h expected %h", obs, expv());
    end
  endtask

  task automatic test_basic_packet();
    bit hb [3] = '{1'b1, 1'b0, 1'b0};
    bit tb [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, hb[i], tb[i], 4'b0001);
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL basic_packet[%0d]: got %h expected %h", i, obs, expv());
      end
    end
    // Independent spot check of the headline result on instance A.
    vectors++;
    if ({a_done, a_size, a_hip, a_nh, a_sz} !== {1'b1, 8'd3, 3'b000}) begin
      miscompares++;
      $display("FAIL basic_size3: got done=%b size=%0d expected done=1 size=3", a_done, a_size);
    end
  endtask

  task automatic test_interleave();
    bit hb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit tb [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] vb [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, hb[i], tb[i], vb[i]);
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL interleave[%0d]: got %h expected %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_no_hdr();
    bit wb [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit hb [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit tb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      apply(wb[i], hb[i], tb[i], 4'b0100);
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL no_hdr[%0d]: got %h expected %h", i, obs, expv());
      end
    end
    vectors++;
    if (a_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL sticky_hold: got %b expected 1", a_sticky);
    end
  endtask

  task automatic test_hdr_in_pck();
    bit hb [3] = '{1'b1, 1'b1, 1'b0};
    bit tb [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, hb[i], tb[i], 4'b0001);
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL hdr_in_pck[%0d]: got %h expected %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_single_flit();
    apply(1'b1, 1'b1, 1'b1, 4'b1000);
    vectors++;
    if (obs !== expv()) begin
      miscompares++;
      $display("FAIL single_flit: got %h expected %h", obs, expv());
    end
    // Header-only flit is a type error on the single-flit instance.
    apply(1'b1, 1'b1, 1'b0, 4'b1000);
    vectors++;
    if (obs !== expv()) begin
      miscompares++;
      $display("FAIL single_type: got %h expected %h", obs, expv());
    end
    apply(1'b1, 1'b0, 1'b1, 4'b1000);
    vectors++;
    if (obs !== expv()) begin
      miscompares++;
      $display("FAIL single_close: got %h expected %h", obs, expv());
    end
  endtask

  task automatic test_onehot();
    logic [3:0] vb [4] = '{4'b0011, 4'b0000, 4'b1111, 4'b0010};
    bit hb [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    bit tb [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    // Open a packet on vc0010 first so a bad write aliasing it would show.
    apply(1'b1, 1'b1, 1'b0, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, hb[i], tb[i], vb[i]);
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL onehot[%0d]: got %h expected %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_saturation();
    apply(1'b1, 1'b1, 1'b0, 4'b0100);
    for (int i = 0; i < 9; i++) apply(1'b1, 1'b0, 1'b0, 4'b0100);
    apply(1'b1, 1'b0, 1'b1, 4'b0100);
    vectors++;
    if (obs !== expv()) begin
      miscompares++;
      $display("FAIL saturation: got %h expected %h", obs, expv());
    end
  endtask

  task automatic test_reset_mid_packet();
    apply(1'b1, 1'b1, 1'b0, 4'b0001);
    apply(1'b1, 1'b0, 1'b0, 4'b0001);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (obs !== expv()) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", obs, expv());
    end
    @(negedge clk);
    reset = 1'b1;
    apply(1'b1, 1'b0, 1'b1, 4'b0001);
    vectors++;
    if (obs !== expv()) begin
      miscompares++;
      $display("FAIL reset_mid_pkt: got %h expected %h", obs, expv());
    end
  endtask

  task automatic test_random();
    bit wr, hdr, tail;
    logic [3:0] vc;
    for (int i = 0; i < 400; i++) begin
      wr   = ($urandom_range(0, 9) < 8);
      hdr  = ($urandom_range(0, 9) < 3);
      tail = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 19) == 0) vc = 4'($urandom_range(0, 15));
      else vc = 4'(1 << $urandom_range(0, 3));
      apply(wr, hdr, tail, vc);
      vectors++;
      if (obs !== expv()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_interleave();
    test_no_hdr();
    test_hdr_in_pck();
    test_single_flit();
    test_onehot();
    test_saturation();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
